// File: rtl/mult8_seq_pkg.sv
// mult8_seq_pkg: shared types and constants for the 8x8 sequential multiplier.
// Holds the FSM state enum, phase width, phase->shift table and phase->half select.
package mult8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PHASE_W = 2;
  localparam int SHIFT_W = 4;

  // Partial-product order ll, lh, hl, hh.
  localparam logic [SHIFT_W-1:0] SHIFT_TBL [4] = '{
    4'd0, 4'd4, 4'd4, 4'd8
  };

  typedef struct packed {
    logic a_hi;
    logic b_hi;
  } half_sel_t;

  // Phase bit 1 picks the high half of a, bit 0 the high half of b.
  function automatic half_sel_t phase_half(
    input logic [PHASE_W-1:0] ph
  );
    half_sel_t s;
    s.a_hi = ph[1];
    s.b_hi = ph[0];
    return s;
  endfunction

endpackage

// File: rtl/mult8_seq_operand_mux.sv
// mult8_seq_operand_mux: selects operand halves and accumulate shift per phase.
// Ports: en, phase, a_r, b_r in; sub_a, sub_b, shift out (all zero when en=0).
module mult8_seq_operand_mux
  import mult8_seq_pkg::*;
#(
  parameter int OPERAND_W = 8,
  parameter int PART_W    = 4
) (
  input  logic                 en,
  input  logic [PHASE_W-1:0]   phase,
  input  logic [OPERAND_W-1:0] a_r,
  input  logic [OPERAND_W-1:0] b_r,
  output logic [PART_W-1:0]    sub_a,
  output logic [PART_W-1:0]    sub_b,
  output logic [SHIFT_W-1:0]   shift
);

  half_sel_t sel;

  always_comb begin
    sel   = phase_half(phase);
    sub_a = '0;
    sub_b = '0;
    shift = '0;
    if (en) begin
      sub_a = sel.a_hi ? a_r[OPERAND_W-1:PART_W]
                       : a_r[PART_W-1:0];
      sub_b = sel.b_hi ? b_r[OPERAND_W-1:PART_W]
                       : b_r[PART_W-1:0];
      shift = SHIFT_TBL[phase];
    end
  end

endmodule

// File: rtl/mult8_seq_sched.sv
// mult8_seq_sched: 8x8 multiplier sharing one external 4x4 core over 4 phases.
// Ports: clk, rst (async high), in_valid/in_ready/a/b, out_valid/out_ready/p,
// busy, sub_a/sub_b to the core, sub_p from the core.
// Optional MULT8_SEQ_SCHED_CHECK_EN adds mismatch and err_cnt outputs.
module mult8_seq_sched
  import mult8_seq_pkg::*;
#(
  parameter int OPERAND_W = 8,
  parameter int PART_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPERAND_W-1:0]   a,
  input  logic [OPERAND_W-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*OPERAND_W-1:0] p,
  output logic                   busy,
  output logic [PART_W-1:0]      sub_a,
  output logic [PART_W-1:0]      sub_b,
  input  logic [2*PART_W-1:0]    sub_p
`ifdef MULT8_SEQ_SCHED_CHECK_EN
  ,
  output logic                   mismatch,
  output logic [7:0]             err_cnt
`endif
);

  localparam int P_W = 2 * OPERAND_W;

  state_t               state_q;
  state_t               state_d;
  logic [PHASE_W-1:0]   phase_q;
  logic [OPERAND_W-1:0] a_r;
  logic [OPERAND_W-1:0] b_r;
  logic [P_W-1:0]       acc;
  logic [P_W-1:0]       acc_nxt;
  logic [SHIFT_W-1:0]   shift;
  logic                 accept;
  logic                 calc_en;
  logic                 last;

  mult8_seq_operand_mux #(
    .OPERAND_W (OPERAND_W),
    .PART_W    (PART_W)
  ) u_mux (
    .en    (calc_en),
    .phase (phase_q),
    .a_r   (a_r),
    .b_r   (b_r),
    .sub_a (sub_a),
    .sub_b (sub_b),
    .shift (shift)
  );

  // Wraps modulo 2^P_W for cores that are not exact.
  assign acc_nxt = acc + (P_W'(sub_p) << shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    calc_en   = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        busy    = 1'b1;
        calc_en = 1'b1;
        if (&phase_q) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      phase_q <= '0;
      p       <= '0;
    end else begin
      if (accept) begin
        a_r     <= a;
        b_r     <= b;
        acc     <= '0;
        phase_q <= '0;
      end
      if (calc_en) begin
        acc     <= acc_nxt;
        phase_q <= phase_q + PHASE_W'(1);
      end
      if (last) p <= acc_nxt;
    end
  end

`ifdef MULT8_SEQ_SCHED_CHECK_EN
  logic [P_W-1:0] exact_p;

  assign exact_p  = P_W'(a_r) * P_W'(b_r);
  assign mismatch = (state_q == DONE) && (p != exact_p);

  // Counted on the DONE entry edge so each product counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (last && (acc_nxt != exact_p)
                 && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult8_seq_sched.sv
// tb_mult8_seq_sched: directed scoreboard bench for mult8_seq_sched.
// Models the shared 4x4 core (exact or with (F,F) forced to 0).
module tb_mult8_seq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;
  logic [3:0]  sub_a;
  logic [3:0]  sub_b;
  logic [7:0]  sub_p;
  logic        bad_core;
`ifdef MULT8_SEQ_SCHED_CHECK_EN
  logic        mismatch;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  assign sub_p = (bad_core && sub_a == 4'hF && sub_b == 4'hF)
               ? 8'h00 : ({4'b0, sub_a} * {4'b0, sub_b});

  mult8_seq_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_p     (sub_p)
`ifdef MULT8_SEQ_SCHED_CHECK_EN
    ,
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
`endif
  );

  function automatic logic [7:0] core_m(input logic [3:0] x, input logic [3:0] y);
    if (bad_core && x == 4'hF && y == 4'hF) return 8'h00;
    return {4'b0, x} * {4'b0, y};
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    return 16'(core_m(x[3:0], y[3:0]))
         + (16'(core_m(x[3:0], y[7:4])) << 4)
         + (16'(core_m(x[7:4], y[3:0])) << 4)
         + (16'(core_m(x[7:4], y[7:4])) << 8);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob,
                        input logic [7:0] na, input logic [7:0] nb,
                        input bit hold, output int waited);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("accept_rdy", in_ready, 1);
    step();
    sb.push_back(model(oa, ob));
    a = na;
    b = nb;
    in_valid = hold;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sub_a_ph%0d", k), sub_a, k[1] ? oa[7:4] : oa[3:0]);
      chk($sformatf("sub_b_ph%0d", k), sub_b, k[0] ? ob[7:4] : ob[3:0]);
      chk($sformatf("calc_flags_ph%0d", k), {busy, in_ready, out_valid}, 3'b100);
      step();
    end
    chk("latency4_valid", out_valid, 1);
  endtask

  task automatic finish_op();
    int n = 0;
    logic [15:0] e;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("drain_valid", out_valid, 1);
    e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
    chk("sb_p", p, e);
    step();
    chk("ov_clear", out_valid, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    bad_core = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {out_valid, busy}, 2'b00);
    chk("rst_p", p, 16'h0000);
    chk("rst_sub", {sub_a, sub_b}, 8'h00);
    rst = 1'b0;
    step();

    out_ready = 1'b1;
    run_op(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, w);
    chk("p_ff_ff", p, 16'hFE01);
    finish_op();
    chk("idle_sub_zero", {sub_a, sub_b}, 8'h00);

    run_op(8'h3C, 8'hA5, 8'h5A, 8'h5A, 1'b0, w);
    chk("p_3c_a5", p, 16'h26AC);
    finish_op();

    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 8'h00, 8'h00, 1'b0, w);
    in_valid = 1'b1;
    a = 8'h77;
    b = 8'h77;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_p", p, 16'h03A8);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    finish_op();
    step();
    chk("bp_no_accept", busy, 0);
    chk("bp_sb_empty", sb.size(), 0);

    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'hAA;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_ph2_sub", {sub_a, sub_b}, 8'h5A);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_flags", {out_valid, busy}, 2'b00);
    chk("mid_rst_p", p, 16'h0000);
    chk("mid_rst_sub", {sub_a, sub_b}, 8'h00);
    step();
    rst = 1'b0;
    run_op(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, w);
    chk("p_after_rst", p, 16'h0006);
    finish_op();

    run_op(8'h00, 8'hFF, 8'h01, 8'h01, 1'b1, w);
    chk("p_b2b_0", p, 16'h0000);
    finish_op();
    run_op(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, w);
    chk("b2b_gap", w, 0);
    chk("p_b2b_1", p, 16'h0001);
    finish_op();

    bad_core = 1'b1;
    run_op(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, w);
    chk("p_bad_ff", p, 16'h0000);
`ifdef MULT8_SEQ_SCHED_CHECK_EN
    chk("mismatch_ff", mismatch, 1);
    chk("err_cnt_ff", err_cnt, 8'd1);
`endif
    finish_op();
    run_op(8'h11, 8'h11, 8'h00, 8'h00, 1'b0, w);
    chk("p_bad_11", p, 16'h0121);
`ifdef MULT8_SEQ_SCHED_CHECK_EN
    chk("mismatch_11", mismatch, 0);
    chk("err_cnt_11", err_cnt, 8'd1);
`endif
    finish_op();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
